// File: rtl/dpb_stream_sequencer_pkg.sv
// Shared types and defaults for the dual-port-buffer stream sequencer.
package dpb_seq_pkg;

  // Sequencer FSM states; encodings are stable so checkers can decode dbg_state.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    TX_FILL      = 3'd1,
    TX_KICK      = 3'd2,
    TX_WAIT_BUSY = 3'd3,
    TX_WAIT_IDLE = 3'd4,
    RX_WAIT      = 3'd5,
    RX_FETCH     = 3'd6,
    RX_OUT       = 3'd7
  } state_e;

  // Cycles allowed for the adapter to leave idle after a TX kick.
  localparam int DEFAULT_BUSY_TIMEOUT = 64;

endpackage

// File: rtl/dpb_stream_sequencer_if.sv
// Bundle of stream, buffer and adapter signals around the sequencer.
//
// Handshakes: a word moves on a rising clk edge where valid && ready are both
// high. The source holds data stable while valid && !ready, and valid never
// depends combinationally on ready. TX: source = user, sink = sequencer
// (i_tx_valid / o_tx_ready). RX: source = sequencer, sink = user
// (o_rx_valid / i_rx_ready).
interface dpb_stream_sequencer_if #(
  parameter int MEM_DEPTH  = 8,
  parameter int DATA_WIDTH = 32
);
  import dpb_seq_pkg::*;

  // TX stream
  logic                  i_tx_stb;
  logic [MEM_DEPTH:0]    i_tx_count;
  logic                  i_tx_valid;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  o_tx_ready;
  logic                  o_tx_done;
  logic                  o_tx_timeout;
  // RX stream
  logic                  i_rx_en;
  logic [MEM_DEPTH:0]    i_rx_count;
  logic                  o_rx_valid;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic                  i_rx_ready;
  logic                  o_rx_done;
  // control / status
  logic                  i_cancel;
  logic                  o_busy;
  // buffer port
  logic                  o_bram_we;
  logic [MEM_DEPTH-1:0]  o_bram_addr;
  logic [DATA_WIDTH-1:0] o_bram_din;
  logic [DATA_WIDTH-1:0] i_bram_dout;
  logic                  i_bram_valid;
  // adapter control
  logic                  o_mem_2_ppfifo_stb;
  logic                  o_ppfifo_2_mem_en;
  logic                  o_cancel_write_stb;
  logic [31:0]           i_num_reads;
  logic                  i_adapter_idle;
  // debug view of the FSM
  state_e                dbg_state;

  // Sequencer side
  modport slave (
    input  i_tx_stb, i_tx_count, i_tx_valid, i_tx_data,
    output o_tx_ready, o_tx_done, o_tx_timeout,
    input  i_rx_en, i_rx_count, i_rx_ready,
    output o_rx_valid, o_rx_data, o_rx_done,
    input  i_cancel,
    output o_busy,
    output o_bram_we, o_bram_addr, o_bram_din,
    input  i_bram_dout, i_bram_valid,
    output o_mem_2_ppfifo_stb, o_ppfifo_2_mem_en, o_cancel_write_stb,
    input  i_num_reads, i_adapter_idle,
    output dbg_state
  );

  // Environment side (user streams, buffer, adapter)
  modport master (
    output i_tx_stb, i_tx_count, i_tx_valid, i_tx_data,
    input  o_tx_ready, o_tx_done, o_tx_timeout,
    output i_rx_en, i_rx_count, i_rx_ready,
    input  o_rx_valid, o_rx_data, o_rx_done,
    output i_cancel,
    input  o_busy,
    input  o_bram_we, o_bram_addr, o_bram_din,
    output i_bram_dout, i_bram_valid,
    input  o_mem_2_ppfifo_stb, o_ppfifo_2_mem_en, o_cancel_write_stb,
    output i_num_reads, i_adapter_idle,
    input  dbg_state
  );

endinterface

// File: rtl/dpb_stream_sequencer.sv
// Stream sequencer: fills the local buffer from a TX stream and kicks the
// adapter to drain it, or waits for an adapter read and streams the buffer out.
module dpb_stream_sequencer
  import dpb_seq_pkg::*;
#(
  parameter int MEM_DEPTH    = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  dpb_stream_sequencer_if.slave  bus
);

  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [MEM_DEPTH-1:0]  idx_q, idx_d;    // TX: next word index
  logic [MEM_DEPTH-1:0]  last_q, last_d;  // index of the final word of the block
  logic [MEM_DEPTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [31:0]           rd_snap_q, rd_snap_d;
  logic                  guard_q, guard_d;
  logic                  we_q, we_d;
  logic                  stb_q, stb_d;
  logic                  rx_en_q, rx_en_d;
  logic                  cancel_q, cancel_d;
  logic                  tx_done_q, tx_done_d;
  logic                  tx_to_q, tx_to_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_done_q, rx_done_d;

  // A count of MEM_SIZE and an illegal 0 both truncate to last index
  // MEM_SIZE-1, so the count MSB never matters for sequencing.
  logic unused_count_msb;
  assign unused_count_msb = bus.i_tx_count[MEM_DEPTH] ^ bus.i_rx_count[MEM_DEPTH];

  // Next-state and output decode; cancel overrides every other transition.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    addr_d     = addr_q;
    din_d      = din_q;
    timer_d    = timer_q;
    rd_snap_d  = rd_snap_q;
    guard_d    = guard_q;
    rx_en_d    = rx_en_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    we_d       = 1'b0;
    stb_d      = 1'b0;
    cancel_d   = 1'b0;
    tx_done_d  = 1'b0;
    tx_to_d    = 1'b0;
    rx_done_d  = 1'b0;
    if (bus.i_cancel && (state_q != IDLE)) begin
      cancel_d   = 1'b1;
      rx_en_d    = 1'b0;
      rx_valid_d = 1'b0;
      state_d    = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_tx_stb) begin
            last_d  = bus.i_tx_count[MEM_DEPTH-1:0] - 1'b1;
            idx_d   = '0;
            addr_d  = '0;
            state_d = TX_FILL;
          end else if (bus.i_rx_en) begin
            last_d    = bus.i_rx_count[MEM_DEPTH-1:0] - 1'b1;
            rd_snap_d = bus.i_num_reads;
            rx_en_d   = 1'b1;
            state_d   = RX_WAIT;
          end
        end
        TX_FILL: begin
          if (bus.i_tx_valid) begin
            we_d   = 1'b1;
            addr_d = idx_q;
            din_d  = bus.i_tx_data;
            idx_d  = idx_q + 1'b1;
            if (idx_q == last_q) state_d = TX_KICK;
          end
        end
        TX_KICK: begin
          // the final buffer write is on the port this cycle
          stb_d   = 1'b1;
          timer_d = '0;
          state_d = TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: begin
          if (!bus.i_adapter_idle) begin
            state_d = TX_WAIT_IDLE;
          end else if (timer_q == TIMER_LAST) begin
            tx_to_d = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        TX_WAIT_IDLE: begin
          if (bus.i_adapter_idle) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
        RX_WAIT: begin
          // plain inequality tolerates counter wrap
          if (bus.i_num_reads != rd_snap_q) begin
            rx_en_d = 1'b0;
            addr_d  = '0;
            guard_d = 1'b1;
            state_d = RX_FETCH;
          end
        end
        RX_FETCH: begin
          // valid seen while the address is still settling refers to the old word
          if (guard_q) begin
            guard_d = 1'b0;
          end else if (bus.i_bram_valid) begin
            rx_data_d  = bus.i_bram_dout;
            rx_valid_d = 1'b1;
            state_d    = RX_OUT;
          end
        end
        RX_OUT: begin
          if (bus.i_rx_ready) begin
            rx_valid_d = 1'b0;
            if (addr_q == last_q) begin
              rx_done_d = 1'b1;
              state_d   = IDLE;
            end else begin
              addr_d  = addr_q + 1'b1;
              guard_d = 1'b1;
              state_d = RX_FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      timer_q    <= '0;
      rd_snap_q  <= '0;
      guard_q    <= 1'b0;
      we_q       <= 1'b0;
      stb_q      <= 1'b0;
      rx_en_q    <= 1'b0;
      cancel_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_to_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      timer_q    <= timer_d;
      rd_snap_q  <= rd_snap_d;
      guard_q    <= guard_d;
      we_q       <= we_d;
      stb_q      <= stb_d;
      rx_en_q    <= rx_en_d;
      cancel_q   <= cancel_d;
      tx_done_q  <= tx_done_d;
      tx_to_q    <= tx_to_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
    end
  end

  assign bus.o_tx_ready         = (state_q == TX_FILL);
  assign bus.o_busy             = (state_q != IDLE);
  assign bus.o_tx_done          = tx_done_q;
  assign bus.o_tx_timeout       = tx_to_q;
  assign bus.o_rx_valid         = rx_valid_q;
  assign bus.o_rx_data          = rx_data_q;
  assign bus.o_rx_done          = rx_done_q;
  assign bus.o_bram_we          = we_q;
  assign bus.o_bram_addr        = addr_q;
  assign bus.o_bram_din         = din_q;
  assign bus.o_mem_2_ppfifo_stb = stb_q;
  assign bus.o_ppfifo_2_mem_en  = rx_en_q;
  assign bus.o_cancel_write_stb = cancel_q;
  assign bus.dbg_state          = state_q;

endmodule

// File: tb/tb_dpb_stream_sequencer.sv
// Self-checking bench for dpb_stream_sequencer.
module tb_dpb_stream_sequencer;
  import dpb_seq_pkg::*;

  localparam int MD = 8;
  localparam int DW = 32;
  localparam int BT = 64;
  localparam int W  = MD + DW;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  dpb_stream_sequencer_if #(.MEM_DEPTH(MD), .DATA_WIDTH(DW)) bus ();

  dpb_stream_sequencer #(.MEM_DEPTH(MD), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- buffer model ----------------
  // Registered read: dout follows the address of the previous cycle, and
  // valid is a stale random flag, so a word read while the address changes
  // is wrong data marked valid.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] bram_dout_q;
  logic          bram_vld_q;
  always @(posedge clk) begin
    bram_dout_q <= mem[bus.o_bram_addr];
    bram_vld_q  <= ($urandom_range(0, 3) != 0);
  end
  assign bus.i_bram_dout  = bram_dout_q;
  assign bus.i_bram_valid = bram_vld_q;

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];   // expected buffer writes {addr, data}
  logic [DW-1:0] rx_q[$];    // expected RX words
  int last_we_cyc, stb_cyc, done_cyc, to_cyc;
  int done_cnt = 0;
  int to_cnt   = 0;
  bit en_seen;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle monitor, run at the falling edge.
  task automatic sample();
    logic [W-1:0] e;
    bit ok;
    if (bus.o_bram_we) begin
      ok = (exp_q.size() != 0);
      check("write_expected", ok, 1);
      if (ok) begin
        e = exp_q.pop_front();
        check("bram_write", {bus.o_bram_addr, bus.o_bram_din}, e);
      end
      last_we_cyc = cyc;
    end
    if (bus.o_mem_2_ppfifo_stb) stb_cyc = cyc;
    if (bus.o_tx_done) begin done_cnt++; done_cyc = cyc; end
    if (bus.o_tx_timeout) begin to_cnt++; to_cyc = cyc; end
    if (bus.o_ppfifo_2_mem_en) en_seen = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    sample();
  endtask

  function automatic logic any_output();
    return |{bus.o_tx_ready, bus.o_tx_done, bus.o_tx_timeout, bus.o_rx_valid,
             bus.o_rx_data, bus.o_rx_done, bus.o_busy, bus.o_bram_we,
             bus.o_bram_addr, bus.o_bram_din, bus.o_mem_2_ppfifo_stb,
             bus.o_ppfifo_2_mem_en, bus.o_cancel_write_stb};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_tx(input int count, input bit rnd, input int idle_low,
                        input bit with_rx, input bit exp_done, input bit exp_to);
    int n, sent, g, done0, to0, idle_hi;
    n = (count == 0) ? 256 : count;
    sent = 0; g = 0; done0 = done_cnt; to0 = to_cnt;
    en_seen = 0; stb_cyc = -1;
    bus.i_tx_stb   = 1'b1;
    bus.i_tx_count = 9'(count);
    bus.i_rx_en    = with_rx;
    tick();
    bus.i_tx_stb = 1'b0;
    bus.i_rx_en  = 1'b0;
    check("tx_busy", bus.o_busy, 1);
    while (sent < n && g < 5000) begin
      bus.i_tx_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.i_tx_data  = $urandom();
      if (bus.i_tx_valid && bus.o_tx_ready) begin
        exp_q.push_back({8'(sent), bus.i_tx_data});
        sent++;
      end
      tick();
      g++;
    end
    bus.i_tx_valid = 1'b0;
    check("tx_fill_words", sent, n);
    check("tx_ready_low_after_fill", bus.o_tx_ready, 0);
    g = 0;
    while (stb_cyc < 0 && g < 10) begin tick(); g++; end
    check("kick_after_last_write", stb_cyc, last_we_cyc + 1);
    check("tx_all_writes_seen", exp_q.size(), 0);
    g = 0;
    if (idle_low > 0) begin
      bus.i_adapter_idle = 1'b0;
      repeat (idle_low) tick();
      bus.i_adapter_idle = 1'b1;
      idle_hi = cyc;
      while (done_cnt == done0 && to_cnt == to0 && g < 20) begin tick(); g++; end
      check("tx_done_latency", done_cyc, idle_hi + 1);
    end else begin
      while (done_cnt == done0 && to_cnt == to0 && g < BT + 20) begin tick(); g++; end
      check("tx_timeout_latency", to_cyc - stb_cyc, BT);
    end
    repeat (3) tick();
    check("tx_done_count", done_cnt - done0, exp_done);
    check("tx_timeout_count", to_cnt - to0, exp_to);
    check("tx_idle_after", bus.o_busy, 0);
    if (with_rx) check("tx_priority_no_rx_en", en_seen, 0);
  endtask

  task automatic run_rx(input int count, input logic [31:0] reads0, input bit rnd);
    int n, acc, g;
    bit rdy, held;
    logic [DW-1:0] held_data, e;
    n = (count == 0) ? 256 : count;
    for (int i = 0; i < n; i++) begin
      mem[i] = $urandom();
      rx_q.push_back(mem[i]);
    end
    bus.i_num_reads = reads0;
    bus.i_rx_count  = 9'(count);
    bus.i_rx_en     = 1'b1;
    tick();
    bus.i_rx_en = 1'b0;   // level may drop; the block still completes
    check("rx_en_asserted", bus.o_ppfifo_2_mem_en, 1);
    repeat (3) tick();
    check("rx_en_held", bus.o_ppfifo_2_mem_en, 1);
    check("rx_wait_no_valid", bus.o_rx_valid, 0);
    bus.i_num_reads = reads0 + 32'd1;
    tick();
    check("rx_en_dropped", bus.o_ppfifo_2_mem_en, 0);
    acc = 0; g = 0; held = 0; held_data = '0;
    while (acc < n && g < 20000) begin
      rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.i_rx_ready = rdy;
      if (held) begin
        check("rx_hold_valid", bus.o_rx_valid, 1);
        check("rx_hold_data", bus.o_rx_data, held_data);
      end
      held = 0;
      if (bus.o_rx_valid) begin
        if (rdy) begin
          e = rx_q.pop_front();
          check("rx_data", bus.o_rx_data, e);
          acc++;
        end else begin
          held = 1;
          held_data = bus.o_rx_data;
        end
      end
      tick();
      g++;
    end
    bus.i_rx_ready = 1'b0;
    check("rx_words", acc, n);
    check("rx_done_pulse", bus.o_rx_done, 1);
    tick();
    check("rx_done_one_cycle", bus.o_rx_done, 0);
    check("rx_idle_after", bus.o_busy, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit          is_tx;
    int          count;
    bit          rnd;
    int          idle_low;
    bit          with_rx;
    bit          exp_done;
    bit          exp_to;
    logic [31:0] reads0;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int g;
    vecs[0] = '{1, 4,   0, 5, 0, 1, 0, 32'd0};          // basic TX
    vecs[1] = '{1, 1,   1, 1, 0, 1, 0, 32'd0};          // single word
    vecs[2] = '{1, 7,   1, 0, 0, 0, 1, 32'd0};          // adapter never busy
    vecs[3] = '{0, 3,   1, 0, 0, 0, 0, 32'd7};          // RX 7->8 with stalls
    vecs[4] = '{0, 5,   0, 0, 0, 0, 0, 32'hFFFF_FFFF};  // read counter wraps
    vecs[5] = '{1, 6,   0, 2, 1, 1, 0, 32'd0};          // tx_stb and rx_en together
    vecs[6] = '{0, 1,   1, 0, 0, 0, 0, 32'd100};        // single RX word
    vecs[7] = '{1, 256, 1, 3, 0, 1, 0, 32'd0};          // full buffer
    vecs[8] = '{0, 0,   1, 0, 0, 0, 0, 32'd55};         // RX count 0 -> 256
    vecs[9] = '{1, 0,   0, 1, 0, 1, 0, 32'd0};          // TX count 0 -> 256

    bus.i_tx_stb = 0; bus.i_tx_count = '0; bus.i_tx_valid = 0; bus.i_tx_data = '0;
    bus.i_rx_en = 0; bus.i_rx_count = '0; bus.i_rx_ready = 0; bus.i_cancel = 0;
    bus.i_num_reads = '0; bus.i_adapter_idle = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    check("reset_outputs_zero", any_output(), 0);
    check("reset_state_idle", 64'(bus.dbg_state), 64'(IDLE));
    rst = 1'b0;
    tick();

    // cancel while idle is ignored
    bus.i_cancel = 1'b1;
    tick();
    bus.i_cancel = 1'b0;
    check("idle_cancel_ignored", bus.o_cancel_write_stb, 0);
    check("idle_cancel_busy", bus.o_busy, 0);

    for (int i = 0; i < 10; i++) begin
      vec_t v;
      v = vecs[i];
      if (v.is_tx) run_tx(v.count, v.rnd, v.idle_low, v.with_rx, v.exp_done, v.exp_to);
      else         run_rx(v.count, v.reads0, v.rnd);
      repeat (2) tick();
    end

    // cancel during TX_FILL after two words
    bus.i_tx_stb = 1'b1; bus.i_tx_count = 9'd8;
    tick();
    bus.i_tx_stb = 1'b0;
    g = 0;
    while (g < 2) begin
      bus.i_tx_valid = 1'b1;
      bus.i_tx_data  = $urandom();
      if (bus.o_tx_ready) exp_q.push_back({8'(g), bus.i_tx_data});
      tick();
      g++;
    end
    bus.i_tx_valid = 1'b0;
    bus.i_cancel   = 1'b1;
    tick();
    bus.i_cancel = 1'b0;
    check("cancel_stb", bus.o_cancel_write_stb, 1);
    check("cancel_tx_ready", bus.o_tx_ready, 0);
    check("cancel_busy", bus.o_busy, 0);
    check("cancel_state", 64'(bus.dbg_state), 64'(IDLE));
    tick();
    check("cancel_stb_one_cycle", bus.o_cancel_write_stb, 0);
    check("cancel_writes_seen", exp_q.size(), 0);

    // reset while holding a word in RX_OUT
    for (int i = 0; i < 3; i++) mem[i] = $urandom();
    bus.i_num_reads = 32'd20; bus.i_rx_count = 9'd3; bus.i_rx_en = 1'b1;
    tick();
    bus.i_rx_en = 1'b0;
    bus.i_num_reads = 32'd21;
    g = 0;
    while (!bus.o_rx_valid && g < 50) begin tick(); g++; end
    check("rx_out_reached", bus.o_rx_valid, 1);
    check("rx_out_state", 64'(bus.dbg_state), 64'(RX_OUT));
    rst = 1'b1;
    tick();
    check("rst_rx_outputs_zero", any_output(), 0);
    check("rst_rx_state_idle", 64'(bus.dbg_state), 64'(IDLE));
    rst = 1'b0;
    repeat (2) tick();

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpb_stream_sequencer.md
Name: dpb_stream_sequencer

Overview:
- Sits in the `clk` domain directly upstream of and beside the dual-port-buffer/ping-pong-FIFO adapter, and owns its user memory interface.
- TX direction: fills the local buffer from a valid/ready word stream, strobes the adapter to drain it into the PPFIFO, and tracks completion via the adapter's idle flag.
- RX direction: enables the adapter's PPFIFO-to-memory path, detects a completed read via the adapter's read counter, then streams buffer contents out on a valid/ready port.

Parameters:
- MEM_DEPTH, 8, buffer address width; MEM_SIZE = 2**MEM_DEPTH words.
- DATA_WIDTH, 32, word width.
- BUSY_TIMEOUT, 64, cycles to wait for adapter idle to drop after a TX kick.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_tx_stb  in  1  start a TX block; sampled only in IDLE.
- i_tx_count  in  MEM_DEPTH+1  words in the TX block, 1..MEM_SIZE; latched on i_tx_stb.
- i_tx_valid  in  1  TX word valid.
- i_tx_data  in  DATA_WIDTH  TX word.
- o_tx_ready  out  1  TX word accepted when valid&&ready.
- o_tx_done  out  1  one-cycle pulse when the TX block has drained.
- o_tx_timeout  out  1  one-cycle pulse when the adapter never went busy.
- i_rx_en  in  1  level request for an RX block.
- i_rx_count  in  MEM_DEPTH+1  words to stream out, 1..MEM_SIZE; latched on RX start.
- o_rx_valid  out  1  RX word valid.
- o_rx_data  out  DATA_WIDTH  RX word, held while valid&&!ready.
- i_rx_ready  in  1  downstream accepts the RX word.
- o_rx_done  out  1  one-cycle pulse after the last RX word is accepted.
- i_cancel  in  1  abort the current operation.
- o_busy  out  1  state != IDLE.
- o_bram_we  out  1  buffer write enable.
- o_bram_addr  out  MEM_DEPTH  buffer address.
- o_bram_din  out  DATA_WIDTH  buffer write data.
- i_bram_dout  in  DATA_WIDTH  buffer read data.
- i_bram_valid  in  1  i_bram_dout is valid for the current o_bram_addr.
- o_mem_2_ppfifo_stb  out  1  one-cycle kick to the adapter.
- o_ppfifo_2_mem_en  out  1  enables the adapter read path.
- o_cancel_write_stb  out  1  one-cycle adapter cancel.
- i_num_reads  in  32  adapter's completed-read counter.
- i_adapter_idle  in  1  adapter idle flag.

Behaviour:
- Reset: all outputs 0 and state IDLE; rd_snap and addr/count registers are cleared.
- IDLE:
  - i_tx_stb has priority over i_rx_en.
  - On i_tx_stb: latch the count, addr=0, go to TX_FILL.
  - Else on i_rx_en: rd_snap<=i_num_reads, assert o_ppfifo_2_mem_en, go to RX_WAIT.
- TX_FILL:
  - o_tx_ready=1.
  - On each handshake: o_bram_we=1 next cycle, with o_bram_addr=index and o_bram_din=data (registered, 1-cycle latency).
  - The index increments after each accepted word.
  - After count words are accepted, deassert ready and go to TX_KICK.
- TX_KICK:
  - Wait one cycle for the last write to retire.
  - Pulse o_mem_2_ppfifo_stb, clear the timer, go to TX_WAIT_BUSY.
- TX_WAIT_BUSY:
  - On !i_adapter_idle, go to TX_WAIT_IDLE.
  - When the timer reaches BUSY_TIMEOUT-1, pulse o_tx_timeout and go to IDLE, with no o_tx_done.
- TX_WAIT_IDLE: on i_adapter_idle, pulse o_tx_done and go to IDLE.
- RX_WAIT: on i_num_reads != rd_snap, drop o_ppfifo_2_mem_en, set addr=0, go to RX_FETCH.
- RX_FETCH:
  - Drive addr and wait for i_bram_valid.
  - Capture i_bram_dout into o_rx_data, assert o_rx_valid, go to RX_OUT.
  - i_bram_valid sampled in the same cycle that addr changes is ignored: one-cycle guard.
- RX_OUT:
  - On i_rx_ready: drop valid.
  - If it was the last word: pulse o_rx_done and go to IDLE.
  - Otherwise: addr+1 and go to RX_FETCH.
- i_cancel: in any non-IDLE state, pulse o_cancel_write_stb, clear all enables/valids, go to IDLE; this takes priority over all other transitions in that cycle. In IDLE it is ignored.
- i_num_reads comparison is plain inequality, so 32-bit wrap is tolerated.
- The count field is MEM_DEPTH+1 bits so MEM_SIZE is representable.
- i_tx_count=0 or i_rx_count=0 is illegal; treat it as MEM_SIZE.
- i_rx_en dropping mid-RX has no effect; the block completes.

Decomposition:
- Shared package dpb_seq_pkg: state enum (IDLE, TX_FILL, TX_KICK, TX_WAIT_BUSY, TX_WAIT_IDLE, RX_WAIT, RX_FETCH, RX_OUT) and the default BUSY_TIMEOUT.
- Single module; no sub-module is warranted.

Test Plan:
- TX of 4 words, i_tx_valid always high: o_bram_we pulses at addr 0..3; o_mem_2_ppfifo_stb fires 1 cycle after the last write; idle low 5 cycles then high gives o_tx_done one cycle later.
- TX with i_adapter_idle held high: o_tx_timeout pulses exactly BUSY_TIMEOUT cycles after the kick, with no o_tx_done.
- RX of 3 words, i_num_reads 7->8: o_ppfifo_2_mem_en drops; words at addr 0..2 are output only after i_bram_valid; o_rx_done fires after the third accept; i_rx_ready stalls hold the data stable.
- i_tx_stb and i_rx_en both asserted in IDLE: TX runs and o_ppfifo_2_mem_en stays 0.
- i_cancel during TX_FILL after 2 words: o_cancel_write_stb pulse, o_tx_ready=0 next cycle, o_busy=0.
- rst asserted in RX_OUT: next cycle all outputs are 0 and state is IDLE; i_tx_count=256 with MEM_DEPTH=8 writes addr 0..255.
